axi_bram_slave: RTL and testbench
=================================

# axi_bram_slave

AXI4 slave that terminates the memory-side AXI port of the L1-to-AXI bridge onto a single-port, 1-cycle-latency block RAM, for the Nexys example system. It serves INCR read bursts (I/D-cache line fills) and single-beat strobed writes (write-through stores) from the same AXI master. Every transaction returns the originating ID on R or B so the bridge can route data back by sub-ID.

## Interface
- MEM_WORDS, 16384, number of 32-bit words; power of two, ≥ 16
- ID_W, 6, AXI ID width; must match `arid`/`awid` driven by the master
- MEM_AW, $clog2(MEM_WORDS), derived; word-address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- axi  modport  axi_interface.slave  AXI4 slave port
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables; 0 means read
- mem_addr  out  MEM_AW  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after a read (`mem_en & mem_we==0`)

## Operation
- AXI signals used:
  - AR: `arvalid`/`arready`, `araddr`, `arlen`, `arid`.
  - R: `rvalid`/`rready`, `rdata`, `rresp`, `rlast`, `rid`.
  - AW: `awvalid`/`awready`, `awaddr`, `awid`.
  - W: `wvalid`/`wready`, `wdata`, `wstrb`.
  - B: `bvalid`/`bready`, `bresp`, `bid`.
- Ignored inputs: `arsize`, `arburst`, `arcache`, `awlen`, `awsize`, `awburst`, `awcache`, `wlast`.
- Writes are always single-beat. Reads are always INCR, 4-byte beats, `arlen`+1 beats (1..256).
- Word address is `addr[MEM_AW+1:2]`; upper bits are dropped.
- Burst address increments by 1 per beat modulo MEM_WORDS, so it wraps at the end of memory.
- `rresp` and `bresp` are always 2'b00 (OKAY).
- FSM states: IDLE, READ, WRITE, BRESP.
- IDLE transitions:
  - Write candidate is `awvalid & wvalid`; read candidate is `arvalid`.
  - If only one candidate is present, it is granted.
  - If both are present, grant goes to the type not granted last. `last_wr` is a flag, reset 0, so the first tie goes to the write.
  - Read grant: `arready`=1; capture `araddr` word, `arlen` and `arid` into the beat counter, address register and `rid`; go to READ.
  - Write grant: `awready`=`wready`=1 in the same cycle; capture address, data, strobe and `awid`; go to WRITE.
- READ:
  - 2-entry R FIFO; its head drives `rdata`, `rlast` and `rvalid`.
  - Issue a BRAM read when beats remain to issue and (FIFO count + reads in flight − pop this cycle) < 2.
  - Each issued read increments the address and lands in the FIFO next cycle.
  - `rlast` is set on the entry for beat `arlen`.
  - On pop of the `rlast` entry, go to IDLE.
- WRITE (1 cycle): `mem_en`=1, `mem_we`=strobe, `mem_addr`/`mem_wdata` from registers; `bvalid` rises the next cycle with `bid`; go to BRESP.
- BRESP: hold `bvalid` and `bid` until `bready`; go to IDLE the next cycle.
- `arready`, `awready` and `wready` are only ever 1 in IDLE.
- `bresp`, `rresp`, `bid` and `rid` remain stable while their valid is high.

## Timing
- Reset values:
  - `arready`, `awready`, `wready`, `rvalid`, `rlast`, `bvalid`, `mem_en`, `mem_we` = 0.
  - `rresp` = `bresp` = 0.
  - FSM IDLE, FIFO empty, in-flight 0, `last_wr` = 0.
- Reset mid-burst or in BRESP abandons the transaction; no further R/B beats are produced.
- Read latency (AR handshake at cycle T, `rready`=1 throughout):
  - first `mem_en` at T+1, first `rvalid` at T+3;
  - one beat per cycle thereafter;
  - `rlast` at T+3+`arlen`;
  - `arready` can be 1 again at T+4+`arlen`.
- With `rready` low the FIFO fills to 2 and BRAM reads stop. No beat is lost or duplicated, and 1 beat/cycle resumes on the first cycle `rready` returns.
- Write latency (AW/W handshake at cycle T): BRAM write at T+1, `bvalid` at T+2; with `bready`=1, next grant possible at T+3.
- An `awvalid` without `wvalid` (or the reverse) is never accepted; it waits for its partner.

## Test plan
- Single read (`araddr`=0x100, `arlen`=0, `arid`=5, mem[0x40]=0xDEADBEEF) -> one beat at T+3: `rdata`=0xDEADBEEF, `rlast`=1, `rid`=5, `rresp`=0.
- 8-beat burst (`araddr`=0x20, `arlen`=7) with `rready` toggling 1,0,0,1… -> words 8..15 in order, exactly 8 beats, `rlast` only on the 8th, FIFO never overflows.
- Write (`awaddr`=0x44, `wdata`=0x11223344, `wstrb`=4'b0101, `awid`=2) then read 0x44 with prior mem=0xAABBCCDD -> `bid`=2, `bvalid` at T+2; read returns 0xAA22CC44.
- Simultaneous `arvalid` and `awvalid`+`wvalid` right after reset -> write granted first, read granted on the next IDLE; repeated ties alternate between read and write.
- Burst at the last word (`araddr`=(MEM_WORDS−2)×4, `arlen`=3) -> words MEM_WORDS−2, MEM_WORDS−1, 0, 1.
- Assert `rst` during the 3rd beat of an `arlen`=15 burst -> all valid/ready outputs 0 the next cycle; a new single read after reset completes normally.

Source files
------------

// File: rtl/axi_bram_slave_if.sv
// AXI4 channel bundle shared by the L1-to-AXI bridge (master) and its memory-side slave.
interface axi_interface #(
    parameter int ID_W = 6
);
    // Read address channel
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [3:0]      arcache;
    logic [ID_W-1:0] arid;
    // Read data channel
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;
    // Write address channel
    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [3:0]      awcache;
    logic [ID_W-1:0] awid;
    // Write data channel
    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    // Write response channel
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arcache, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst, awcache, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arcache, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst, awcache, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );
endinterface

// File: rtl/axi_bram_slave.sv
// AXI4 slave onto a single-port, 1-cycle-latency BRAM: INCR read bursts and
// single-beat strobed writes, with read/write fairness on simultaneous requests.
module axi_bram_slave #(
    parameter int MEM_WORDS = 16384,
    parameter int ID_W      = 6,
    parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    axi_interface.slave       axi,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] BRESP = 2'd3;

    logic [1:0]        state;
    logic              last_wr;

    logic [MEM_AW-1:0] rd_addr;
    logic [8:0]        rd_left;
    logic [ID_W-1:0]   rd_id;
    logic              rd_pend;
    logic              rd_pend_last;

    logic [MEM_AW-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [ID_W-1:0]   wr_id;
    logic              bvalid_r;

    logic [31:0]       fifo_data [2];
    logic              fifo_last [2];
    logic              fifo_rd_ptr;
    logic              fifo_wr_ptr;
    logic [1:0]        fifo_cnt;

    logic              wr_cand;
    logic              rd_cand;
    logic              in_idle;
    logic              grant_wr;
    logic              grant_rd;
    logic              rvalid_int;
    logic              rlast_int;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;

    logic              unused_inputs;
    assign unused_inputs = ^{axi.arsize, axi.arburst, axi.arcache,
                             axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.wlast,
                             axi.araddr[31:MEM_AW+2], axi.araddr[1:0],
                             axi.awaddr[31:MEM_AW+2], axi.awaddr[1:0]};

    // Arbitration, FIFO status and BRAM read issue decision
    always_comb begin
        wr_cand    = axi.awvalid & axi.wvalid;
        rd_cand    = axi.arvalid;
        // Readies are masked by rst so no handshake is seen that the reset would discard.
        in_idle    = (state == IDLE) & ~rst;
        grant_wr   = in_idle & wr_cand & (~rd_cand | ~last_wr);
        grant_rd   = in_idle & rd_cand & ~grant_wr;
        rvalid_int = (fifo_cnt != 2'd0);
        rlast_int  = rvalid_int & fifo_last[fifo_rd_ptr];
        pop        = rvalid_int & axi.rready;
        // A read in flight already owns a FIFO slot; a pop this cycle frees one.
        occupancy  = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        issue      = (state == READ) & (rd_left != 9'd0) & (occupancy < 3'd2);
    end

    assign axi.arready = grant_rd;
    assign axi.awready = grant_wr;
    assign axi.wready  = grant_wr;
    assign axi.rvalid  = rvalid_int;
    assign axi.rdata   = fifo_data[fifo_rd_ptr];
    assign axi.rlast   = rlast_int;
    assign axi.rresp   = 2'b00;
    assign axi.rid     = rd_id;
    assign axi.bvalid  = bvalid_r;
    assign axi.bresp   = 2'b00;
    assign axi.bid     = wr_id;

    // BRAM port: write slot in WRITE, otherwise burst reads as issued
    always_comb begin
        mem_en    = issue | (state == WRITE);
        mem_we    = (state == WRITE) ? wr_strb : '0;
        mem_addr  = (state == WRITE) ? wr_addr : rd_addr;
        mem_wdata = wr_data;
    end

    // Main FSM: grant capture, burst address/beat tracking, write and response phases
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_wr      <= 1'b0;
            rd_left      <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            bvalid_r     <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= (rd_left == 9'd1);
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        state   <= WRITE;
                        last_wr <= 1'b1;
                        wr_addr <= axi.awaddr[MEM_AW+1:2];
                        wr_data <= axi.wdata;
                        wr_strb <= axi.wstrb;
                        wr_id   <= axi.awid;
                    end else if (grant_rd) begin
                        state   <= READ;
                        last_wr <= 1'b0;
                        rd_addr <= axi.araddr[MEM_AW+1:2];
                        rd_left <= {1'b0, axi.arlen} + 9'd1;
                        rd_id   <= axi.arid;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + MEM_AW'(1);
                        rd_left <= rd_left - 9'd1;
                    end
                    if (pop && rlast_int) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    bvalid_r <= 1'b1;
                    state    <= BRESP;
                end
                default: begin
                    if (axi.bready) begin
                        bvalid_r <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    // Two-entry R FIFO: BRAM returns land here, head drives the R channel
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt    <= '0;
            fifo_rd_ptr <= 1'b0;
            fifo_wr_ptr <= 1'b0;
        end else begin
            if (rd_pend) begin
                fifo_data[fifo_wr_ptr] <= mem_rdata;
                fifo_last[fifo_wr_ptr] <= rd_pend_last;
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(rd_pend) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_axi_bram_slave.sv
// Randomized bench for axi_bram_slave with a word-array memory reference model.
module tb_axi_bram_slave;

    localparam int MW  = 256;
    localparam int AW  = 8;
    localparam int IDW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_interface #(.ID_W(IDW)) axi ();

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    axi_bram_slave #(.MEM_WORDS(MW), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Block RAM with 1-cycle read latency and byte enables
    logic [31:0] bram     [MW];
    logic [31:0] init_mem [MW];
    logic        load;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < MW; i++) bram[i] <= init_mem[i];
        end else if (mem_en) begin
            if (mem_we == 4'b0000) mem_rdata <= bram[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ref_mem [MW];
    bit          last_was_wr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % MW);
    endfunction

    function automatic bit pick_rready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ignored;
        axi.arsize  = 3'($urandom);
        axi.arburst = 2'($urandom);
        axi.arcache = 4'($urandom);
        axi.awlen   = 8'($urandom);
        axi.awsize  = 3'($urandom);
        axi.awburst = 2'($urandom);
        axi.awcache = 4'($urandom);
        axi.wlast   = 1'($urandom);
    endtask

    task automatic wait_ar(output int t);
        bit ok = 0;
        int n  = 0;
        t = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (axi.arready) begin ok = 1; t = cyc; end
            else step;
            n++;
        end
        check("ar_handshake", ok, 1);
    endtask

    task automatic wait_aw(output int t);
        bit ok = 0;
        int n  = 0;
        t = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (axi.awready || axi.wready) begin
                ok = 1;
                t  = cyc;
                check("aw_w_same_cycle", {axi.awready, axi.wready}, 2'b11);
            end else step;
            n++;
        end
        check("aw_handshake", ok, 1);
    endtask

    // Collect a read burst whose AR handshake was at cycle t0 (called at that negedge).
    task automatic rd_finish(input logic [31:0] addr, input int len, input logic [IDW-1:0] id,
                             input int t0, input int mode, input bit drop_other);
        int beat = 0;
        int k    = 0;
        bit done = 0;
        int base = word_of(addr);
        while (!done && k < 3000) begin
            step;
            if (k == 0) begin
                axi.arvalid = 0;
                if (drop_other) begin axi.awvalid = 0; axi.wvalid = 0; end
            end
            axi.rready = pick_rready(mode, k);
            k++;
            @(negedge clk);
            if (mode == 0 && cyc == t0 + 2) check("rd_not_early", axi.rvalid, 0);
            if (axi.rvalid && axi.rready) begin
                check("rd_data", axi.rdata, ref_mem[(base + beat) % MW]);
                check("rd_last", axi.rlast, beat == len);
                check("rd_id", axi.rid, id);
                check("rd_resp", axi.rresp, 0);
                if (mode == 0) check("rd_beat_cycle", cyc, t0 + 3 + beat);
                done = axi.rlast || beat >= len;
                beat++;
            end
        end
        check("rd_beat_count", beat, len + 1);
    endtask

    // Follow a write whose AW/W handshake was at cycle t0 (called at that negedge).
    task automatic wr_finish(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [IDW-1:0] id, input int t0, input int dly, input bit drop_other);
        int n = 0;
        int w = word_of(addr);
        step;
        axi.awvalid = 0;
        axi.wvalid  = 0;
        if (drop_other) axi.arvalid = 0;
        axi.bready  = 0;
        @(negedge clk);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_we", mem_we, strb);
        check("wr_mem_addr", mem_addr, w);
        check("wr_mem_wdata", mem_wdata, data);
        check("wr_b_not_early", axi.bvalid, 0);
        step;
        axi.bready = (dly == 0);
        @(negedge clk);
        check("wr_bvalid", axi.bvalid, 1);
        check("wr_bid", axi.bid, id);
        check("wr_bresp", axi.bresp, 0);
        while (!(axi.bvalid && axi.bready) && n < dly + 5) begin
            step;
            n++;
            axi.bready = (n >= dly);
            @(negedge clk);
            check("wr_b_hold", axi.bvalid, 1);
            check("wr_bid_hold", axi.bid, id);
        end
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic rd(input logic [31:0] addr, input int len, input logic [IDW-1:0] id, input int mode);
        int t;
        step;
        randomize_ignored();
        axi.araddr  = addr;
        axi.arlen   = 8'(len);
        axi.arid    = id;
        axi.arvalid = 1;
        wait_ar(t);
        last_was_wr = 0;
        rd_finish(addr, len, id, t, mode, 0);
        step;
        axi.rready = 0;
        @(negedge clk);
        check("rd_no_extra", axi.rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [IDW-1:0] id, input int dly, input int pre);
        int t;
        step;
        randomize_ignored();
        axi.awaddr = addr;
        axi.awid   = id;
        axi.wdata  = data;
        axi.wstrb  = strb;
        if (pre > 0) begin
            bit which;
            which = 1'($urandom_range(0, 1));
            axi.awvalid = which;
            axi.wvalid  = !which;
            for (int i = 0; i < pre; i++) begin
                @(negedge clk);
                check("half_not_accepted", {axi.awready, axi.wready}, 2'b00);
                step;
            end
        end
        axi.awvalid = 1;
        axi.wvalid  = 1;
        wait_aw(t);
        last_was_wr = 1;
        wr_finish(addr, data, strb, id, t, dly, 0);
    endtask

    // Simultaneous read and write request; the loser is either served next or withdrawn.
    task automatic tie(input bit serve_loser);
        logic [31:0]    ra, wa, wd;
        logic [3:0]     ws;
        logic [IDW-1:0] rid_v, wid_v;
        int             rl, t, t2;
        bit             exp_w;
        ra    = $urandom;
        rl    = $urandom_range(0, 3);
        rid_v = IDW'($urandom);
        wa    = $urandom;
        wd    = $urandom;
        ws    = 4'($urandom_range(1, 15));
        wid_v = IDW'($urandom);
        step;
        randomize_ignored();
        axi.araddr  = ra;
        axi.arlen   = 8'(rl);
        axi.arid    = rid_v;
        axi.arvalid = 1;
        axi.awaddr  = wa;
        axi.awid    = wid_v;
        axi.wdata   = wd;
        axi.wstrb   = ws;
        axi.awvalid = 1;
        axi.wvalid  = 1;
        axi.rready  = 1;
        @(negedge clk);
        exp_w = !last_was_wr;
        check("tie_awready", axi.awready, exp_w);
        check("tie_arready", axi.arready, !exp_w);
        t = cyc;
        if (axi.awready) begin
            last_was_wr = 1;
            wr_finish(wa, wd, ws, wid_v, t, 0, !serve_loser);
            if (serve_loser) begin
                step;
                wait_ar(t2);
                check("tie_rd_grant_cycle", t2, t + 3);
                last_was_wr = 0;
                rd_finish(ra, rl, rid_v, t2, 0, 0);
            end
        end else if (axi.arready) begin
            last_was_wr = 0;
            rd_finish(ra, rl, rid_v, t, 0, !serve_loser);
            if (serve_loser) begin
                step;
                wait_aw(t2);
                check("tie_wr_grant_cycle", t2, t + 4 + rl);
                last_was_wr = 1;
                wr_finish(wa, wd, ws, wid_v, t2, 0, 0);
            end
        end else begin
            step;
            axi.arvalid = 0;
            axi.awvalid = 0;
            axi.wvalid  = 0;
        end
    endtask

    task automatic do_reset;
        rst         = 1;
        axi.arvalid = 0;
        axi.awvalid = 0;
        axi.wvalid  = 0;
        axi.rready  = 0;
        axi.bready  = 0;
        repeat (3) step;
        @(negedge clk);
        check("rst_arready", axi.arready, 0);
        check("rst_awready", axi.awready, 0);
        check("rst_wready", axi.wready, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rlast", axi.rlast, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rresp", axi.rresp, 0);
        check("rst_bresp", axi.bresp, 0);
        step;
        rst = 0;
        last_was_wr = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [31:0] ra;
        for (int i = 0; i < MW; i++) begin
            init_mem[i] = $urandom;
            ref_mem[i]  = init_mem[i];
        end
        init_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40]  = 32'hDEADBEEF;
        init_mem[32'h11] = 32'hAABBCCDD;
        ref_mem[32'h11]  = 32'hAABBCCDD;
        axi.arvalid = 0; axi.araddr = '0; axi.arlen = '0; axi.arid = '0;
        axi.awvalid = 0; axi.awaddr = '0; axi.awid = '0;
        axi.wvalid  = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.rready  = 0; axi.bready = 0;
        randomize_ignored();
        rst  = 1;
        load = 1;
        step;
        load = 0;
        do_reset();

        // Ties straight after reset: write first, then fairness alternation
        tie(1);
        tie(1);
        tie(0);
        tie(0);
        tie(1);

        // Directed reads and the strobed write merge
        rd(32'h100, 0, 6'd5, 0);
        rd(32'h20, 7, 6'd9, 1);
        wr(32'h44, 32'h11223344, 4'b0101, 6'd2, 0, 0);
        rd(32'h44, 0, 6'd3, 0);
        rd((MW - 2) * 4, 3, 6'd7, 0);
        rd(32'hFFFF_0000 | ((MW - 1) * 4), 5, 6'd33, 2);

        // Random mix of bursts and writes with back-pressure
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_F3FF;
            if ($urandom_range(0, 1) == 0)
                rd(a, $urandom_range(0, 20), IDW'($urandom), $urandom_range(0, 2));
            else
                wr(a, $urandom, 4'($urandom_range(1, 15)), IDW'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset in the middle of a 16-beat burst
        ra = $urandom;
        step;
        axi.araddr  = ra;
        axi.arlen   = 8'd15;
        axi.arid    = 6'd17;
        axi.arvalid = 1;
        axi.rready  = 1;
        wait_ar(t);
        step;
        axi.arvalid = 0;
        while (cyc < t + 5 && t >= 0) step;
        @(negedge clk);
        check("rst_mid_beat3_valid", axi.rvalid, 1);
        check("rst_mid_beat3_data", axi.rdata, ref_mem[(word_of(ra) + 2) % MW]);
        rst         = 1;
        axi.arvalid = 1;
        axi.awvalid = 1;
        axi.wvalid  = 1;
        axi.bready  = 1;
        step;
        @(negedge clk);
        check("rst_mid_rvalid", axi.rvalid, 0);
        check("rst_mid_rlast", axi.rlast, 0);
        check("rst_mid_arready", axi.arready, 0);
        check("rst_mid_awready", axi.awready, 0);
        check("rst_mid_wready", axi.wready, 0);
        check("rst_mid_bvalid", axi.bvalid, 0);
        check("rst_mid_mem_en", mem_en, 0);
        step;
        rst         = 0;
        axi.arvalid = 0;
        axi.awvalid = 0;
        axi.wvalid  = 0;
        last_was_wr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stray_r", axi.rvalid, 0);
            check("rst_no_stray_b", axi.bvalid, 0);
            step;
        end
        @(negedge clk);
        rd($urandom, 0, 6'd21, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
